// File: rtl/gpu_prim_load_sequencer.sv
// GP0 primitive parameter sequencer: pops polygon/rectangle words into the vertex register file.
// Define GPU_RECT_SEQ_EN to sequence rectangles (0x60-0x7F); otherwise they are dropped as unsupported.
module gpu_prim_load_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fifoValid,
    input  logic [31:0] i_fifoData,
    output logic        o_fifoRead,
    output logic        o_validData,
    output logic [31:0] o_data,
    output logic [7:0]  o_command,
    output logic [1:0]  o_targetVertex,
    output logic        o_loadVertices,
    output logic        o_loadUV,
    output logic        o_loadRGB,
    output logic        o_loadAllRGB,
    output logic        o_loadSize,
    output logic [1:0]  o_loadSizeParam,
    output logic        o_loadRectEdge,
    output logic        o_isVertexLoadState,
    output logic        o_bUseTexture,
    output logic        o_bIgnoreColor,
    output logic        o_primValid,
    input  logic        i_primAck,
    output logic        o_unsupported,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_COLOR,
        S_VERTEX,
        S_UV
`ifdef GPU_RECT_SEQ_EN
        , S_SIZE
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] vi_q, vi_d;
    logic [7:0] cmd_q, cmd_d;
    logic       primValid_q;
    logic       unsupported_q, unsupported_d;

    logic [7:0] cmd;
    logic       gouraud, quad, tex, isPoly, go;
    logic [1:0] slot;
    state_t     polyNext;
    logic [1:0] polyNextVi;
`ifdef GPU_RECT_SEQ_EN
    logic       isRect;
    logic [1:0] rsize;
    state_t     rectNext;
`endif

    // In IDLE the flags come straight from the head word so the first word can be decoded and consumed.
    assign cmd     = (state_q == S_IDLE) ? i_fifoData[31:24] : cmd_q;
    assign gouraud = cmd[4];
    assign quad    = cmd[3];
    assign tex     = cmd[2];
    assign isPoly  = (cmd[7:5] == 3'b001);
    assign go      = i_fifoValid & ~i_rst;
    assign slot    = (vi_q == 2'd3) ? 2'd0 : vi_q;

    // vi of 2 or 3 means the current triangle's last vertex has just been loaded.
    assign polyNext   = vi_q[1] ? S_EMIT : (gouraud ? S_COLOR : S_VERTEX);
    assign polyNextVi = vi_q[1] ? vi_q : vi_q + 2'd1;

`ifdef GPU_RECT_SEQ_EN
    assign isRect   = (cmd[7:5] == 3'b011);
    assign rsize    = cmd[4:3];
    assign rectNext = (rsize == 2'd0) ? S_SIZE : S_EMIT;
`endif

    assign o_validData   = o_fifoRead;
    assign o_data        = i_fifoData;
    assign o_command     = cmd;
    assign o_bUseTexture = cmd[2];
    assign o_bIgnoreColor = cmd[2] & cmd[0];
    assign o_primValid   = primValid_q;
    assign o_unsupported = unsupported_q;
    assign o_busy        = (state_q != S_IDLE);

    always_comb begin
        state_d             = state_q;
        vi_d                = vi_q;
        cmd_d               = cmd_q;
        unsupported_d       = 1'b0;
        o_fifoRead          = 1'b0;
        o_targetVertex      = 2'd0;
        o_loadVertices      = 1'b0;
        o_loadUV            = 1'b0;
        o_loadRGB           = 1'b0;
        o_loadAllRGB        = 1'b0;
        o_loadSize          = 1'b0;
        o_loadSizeParam     = 2'd0;
        o_loadRectEdge      = 1'b0;
        o_isVertexLoadState = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    o_fifoRead = 1'b1;
                    cmd_d      = i_fifoData[31:24];
                    vi_d       = 2'd0;
                    if (isPoly) begin
                        o_loadRGB    = 1'b1;
                        o_loadAllRGB = ~gouraud;
                        state_d      = S_VERTEX;
                    end
`ifdef GPU_RECT_SEQ_EN
                    else if (isRect) begin
                        o_loadRGB    = 1'b1;
                        o_loadAllRGB = 1'b1;
                        state_d      = S_VERTEX;
                    end
`endif
                    else begin
                        unsupported_d = 1'b1;
                    end
                end
            end
            S_COLOR: begin
                if (go) begin
                    o_fifoRead     = 1'b1;
                    o_loadRGB      = 1'b1;
                    o_targetVertex = slot;
                    state_d        = S_VERTEX;
                end
            end
            S_VERTEX: begin
                if (go) begin
                    o_fifoRead     = 1'b1;
                    o_loadVertices = 1'b1;
                    o_targetVertex = slot;
`ifdef GPU_RECT_SEQ_EN
                    if (isRect) begin
                        o_targetVertex = 2'd0;
                        if (rsize != 2'd0) begin
                            o_loadSize          = 1'b1;
                            o_loadRectEdge      = 1'b1;
                            o_isVertexLoadState = 1'b1;
                            o_loadSizeParam     = rsize;
                        end
                        state_d = tex ? S_UV : rectNext;
                    end else
`endif
                    if (tex) begin
                        state_d = S_UV;
                    end else begin
                        state_d = polyNext;
                        vi_d    = polyNextVi;
                    end
                end
            end
            S_UV: begin
                if (go) begin
                    o_fifoRead     = 1'b1;
                    o_loadUV       = 1'b1;
                    o_targetVertex = slot;
`ifdef GPU_RECT_SEQ_EN
                    if (isRect) begin
                        state_d = rectNext;
                    end else
`endif
                    begin
                        state_d = polyNext;
                        vi_d    = polyNextVi;
                    end
                end
            end
`ifdef GPU_RECT_SEQ_EN
            S_SIZE: begin
                if (go) begin
                    o_fifoRead     = 1'b1;
                    o_loadSize     = 1'b1;
                    o_loadRectEdge = 1'b1;
                    state_d        = S_EMIT;
                end
            end
`endif
            S_EMIT: begin
                if (i_primAck) begin
                    // Second quad triangle reuses slots 1 and 2 and only reloads slot 0 (vi = 3).
                    if (isPoly && quad && (vi_q == 2'd2)) begin
                        vi_d    = 2'd3;
                        state_d = gouraud ? S_COLOR : S_VERTEX;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            vi_q          <= 2'd0;
            cmd_q         <= 8'h00;
            primValid_q   <= 1'b0;
            unsupported_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vi_q          <= vi_d;
            cmd_q         <= cmd_d;
            primValid_q   <= (state_d == S_EMIT);
            unsupported_q <= unsupported_d;
        end
    end

endmodule

// File: tb/tb_gpu_prim_load_sequencer.sv
// Randomized bench for gpu_prim_load_sequencer against a per-primitive word/emit expectation model.
module tb_gpu_prim_load_sequencer;

    logic        clk = 1'b0;
    logic        i_rst, i_fifoValid, i_primAck;
    logic [31:0] i_fifoData;
    logic        o_fifoRead, o_validData;
    logic [31:0] o_data;
    logic [7:0]  o_command;
    logic [1:0]  o_targetVertex, o_loadSizeParam;
    logic        o_loadVertices, o_loadUV, o_loadRGB, o_loadAllRGB, o_loadSize;
    logic        o_loadRectEdge, o_isVertexLoadState, o_bUseTexture, o_bIgnoreColor;
    logic        o_primValid, o_unsupported, o_busy;

    always #5 clk = ~clk;

    gpu_prim_load_sequencer dut (
        .i_clk(clk), .i_rst(i_rst), .i_fifoValid(i_fifoValid), .i_fifoData(i_fifoData),
        .o_fifoRead(o_fifoRead), .o_validData(o_validData), .o_data(o_data),
        .o_command(o_command), .o_targetVertex(o_targetVertex),
        .o_loadVertices(o_loadVertices), .o_loadUV(o_loadUV), .o_loadRGB(o_loadRGB),
        .o_loadAllRGB(o_loadAllRGB), .o_loadSize(o_loadSize), .o_loadSizeParam(o_loadSizeParam),
        .o_loadRectEdge(o_loadRectEdge), .o_isVertexLoadState(o_isVertexLoadState),
        .o_bUseTexture(o_bUseTexture), .o_bIgnoreColor(o_bIgnoreColor),
        .o_primValid(o_primValid), .i_primAck(i_primAck), .o_unsupported(o_unsupported),
        .o_busy(o_busy)
    );

    // {vert, uv, rgb, allRgb, size, sizeParam[1:0], rectEdge, isVertexLoad, target[1:0]}
    logic [10:0] dut_strb;
    assign dut_strb = {o_loadVertices, o_loadUV, o_loadRGB, o_loadAllRGB, o_loadSize,
                       o_loadSizeParam, o_loadRectEdge, o_isVertexLoadState, o_targetVertex};

    typedef struct {
        bit          emit;
        bit          unsup;
        logic [10:0] strb;
        logic [7:0]  cmd;
    } item_t;

    item_t       iq[$];
    logic [31:0] wq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          unsup_exp = 1'b0;
    int          emit_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input bit v, input bit uv, input bit rgb, input bit all,
                                       input bit sz, input bit [1:0] prm, input bit edg,
                                       input bit isvl, input bit [1:0] tgt);
        return {v, uv, rgb, all, sz, prm, edg, isvl, tgt};
    endfunction

    task automatic push_word(input logic [31:0] w, input logic [7:0] c, input logic [10:0] s,
                             input bit u);
        item_t it;
        it.emit = 1'b0; it.unsup = u; it.strb = s; it.cmd = c;
        wq.push_back(w);
        iq.push_back(it);
    endtask

    task automatic push_emit(input logic [7:0] c);
        item_t it;
        it.emit = 1'b1; it.unsup = 1'b0; it.strb = '0; it.cmd = c;
        iq.push_back(it);
    endtask

    // Expected word-by-word behaviour of one command, derived from the primitive's shape.
    task automatic add_prim(input logic [7:0] c);
        bit          g, q, t;
        logic [1:0]  rs;
        logic [31:0] first;
        g = c[4]; q = c[3]; t = c[2]; rs = c[4:3];
        first = {c, 24'($urandom)};
        if (c[7:5] == 3'b001) begin
            for (int k = 0; k < 3; k++) begin
                if (k == 0)
                    push_word(first, c, mk(0, 0, 1, !g, 0, 2'd0, 0, 0, 2'd0), 0);
                else if (g)
                    push_word($urandom, c, mk(0, 0, 1, 0, 0, 2'd0, 0, 0, 2'(k)), 0);
                push_word($urandom, c, mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'(k)), 0);
                if (t) push_word($urandom, c, mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 2'(k)), 0);
            end
            push_emit(c);
            if (q) begin
                if (g) push_word($urandom, c, mk(0, 0, 1, 0, 0, 2'd0, 0, 0, 2'd0), 0);
                push_word($urandom, c, mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0), 0);
                if (t) push_word($urandom, c, mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 2'd0), 0);
                push_emit(c);
            end
        end
`ifdef GPU_RECT_SEQ_EN
        else if (c[7:5] == 3'b011) begin
            push_word(first, c, mk(0, 0, 1, 1, 0, 2'd0, 0, 0, 2'd0), 0);
            if (rs != 2'd0)
                push_word($urandom, c, mk(1, 0, 0, 0, 1, rs, 1, 1, 2'd0), 0);
            else
                push_word($urandom, c, mk(1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0), 0);
            if (t) push_word($urandom, c, mk(0, 1, 0, 0, 0, 2'd0, 0, 0, 2'd0), 0);
            if (rs == 2'd0) push_word($urandom, c, mk(0, 0, 0, 0, 1, 2'd0, 1, 0, 2'd0), 0);
            push_emit(c);
        end
`endif
        else begin
            push_word(first, c, '0, 1);
        end
    endtask

    task automatic run_stream(input int vpct, input bit alt, input int ack_delay);
        int budget;
        bit par;
        budget = 0;
        par = 1'b1;
        while ((iq.size() > 0 || unsup_exp) && budget < 5000) begin
            budget++;
            @(posedge clk); #1;
            if (iq.size() > 0 && iq[0].emit) begin
                i_primAck = (emit_cnt >= ack_delay);
                emit_cnt++;
            end else begin
                i_primAck = ($urandom_range(0, 3) == 0);
            end
            i_fifoValid = (wq.size() > 0) && (alt ? par : ($urandom_range(1, 100) <= vpct));
            par = ~par;
            i_fifoData = (wq.size() > 0) ? wq[0] : $urandom;
            @(negedge clk);
            check("unsupported", o_unsupported, unsup_exp);
            unsup_exp = 1'b0;
            check("data_pass", o_data, i_fifoData);
            check("validData", o_validData, o_fifoRead);
            if (iq.size() == 0) begin
                check("idle_read", o_fifoRead, 1'b0);
                check("idle_primValid", o_primValid, 1'b0);
            end else if (iq[0].emit) begin
                check("emit_primValid", o_primValid, 1'b1);
                check("emit_noread", o_fifoRead, 1'b0);
                check("emit_strobes", dut_strb[10:2], 9'd0);
                if (i_primAck) begin
                    void'(iq.pop_front());
                    emit_cnt = 0;
                end
            end else begin
                check("word_primValid", o_primValid, 1'b0);
                check("word_read", o_fifoRead, i_fifoValid);
                if (i_fifoValid) begin
                    check("strobes", dut_strb, iq[0].strb);
                    check("command", o_command, iq[0].cmd);
                    check("useTexture", o_bUseTexture, iq[0].cmd[2]);
                    check("ignoreColor", o_bIgnoreColor, iq[0].cmd[2] & iq[0].cmd[0]);
                    unsup_exp = iq[0].unsup;
                    void'(iq.pop_front());
                    void'(wq.pop_front());
                end else begin
                    check("bubble_strobes", dut_strb[10:2], 9'd0);
                end
            end
        end
        check("drain", iq.size(), 0);
        @(posedge clk); #1;
        i_fifoValid = 1'b0;
        i_primAck   = 1'b0;
        @(negedge clk);
        check("end_busy", o_busy, 1'b0);
    endtask

    initial begin
        logic [7:0] c;
        i_rst = 1'b1; i_fifoValid = 1'b1; i_fifoData = 32'h2000_0000; i_primAck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read", o_fifoRead, 1'b0);
        check("rst_strobes", dut_strb[10:2], 9'd0);
        check("rst_primValid", o_primValid, 1'b0);
        check("rst_unsupported", o_unsupported, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        @(posedge clk); #1;
        i_rst = 1'b0; i_fifoValid = 1'b0;

        // flat triangle, back to back
        add_prim(8'h20);
        run_stream(100, 0, 0);
        // gouraud textured quad, ack held off 3 cycles
        add_prim(8'h3C);
        run_stream(100, 0, 3);
        add_prim(8'h74);
        run_stream(100, 0, 1);
`ifdef GPU_RECT_SEQ_EN
        add_prim(8'h60);
`else
        add_prim(8'h60);
        push_word(32'h0010_0010, 8'h00, '0, 1);
        push_word(32'h0020_0010, 8'h00, '0, 1);
`endif
        run_stream(100, 0, 0);

        // reset after the second word of a gouraud triangle
        @(posedge clk); #1;
        i_fifoValid = 1'b1; i_fifoData = 32'h3011_2233;
        @(negedge clk);
        check("mid_read0", o_fifoRead, 1'b1);
        @(posedge clk); #1;
        i_fifoData = 32'h0004_0005;
        @(negedge clk);
        check("mid_read1", o_fifoRead, 1'b1);
        check("mid_busy", o_busy, 1'b1);
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(negedge clk);
        check("mid_rst_read", o_fifoRead, 1'b0);
        @(posedge clk); #1;
        i_rst = 1'b0; i_fifoValid = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_primValid", o_primValid, 1'b0);
        add_prim(8'h20);
        run_stream(100, 0, 0);

        // alternating FIFO bubbles
        add_prim(8'h30);
        run_stream(100, 1, 0);

        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < 10; p++) begin
                case ($urandom_range(0, 4))
                    0, 1, 2: c = {3'b001, 5'($urandom)};
                    3:       c = {3'b011, 5'($urandom)};
                    default: begin
                        c = 8'($urandom);
                        if (c[6:5] == 2'b01) c = c ^ 8'h80;
                    end
                endcase
                add_prim(c);
            end
            run_stream(60 + 10 * b, 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_prim_load_sequencer.md
# gpu_prim_load_sequencer

Command-word sequencer between the GP0 command FIFO and the vertex/attribute register file (`gpu_loadedRegs`). It decodes polygon (0x20–0x3F) and rectangle (0x60–0x7F) commands and pops their parameter words one per cycle. For each word it drives the register file's target-vertex and load strobes. When a primitive is fully loaded, it hands the primitive to the rasterizer with a valid/ack handshake.

## Interface
- No parameters.
- `i_clk` in 1: system clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_fifoValid` in 1: FIFO word available.
- `i_fifoData` in 32: FIFO head word.
- `o_fifoRead` out 1: pop strobe, asserted same cycle the word is consumed.
- `o_validData` out 1: word valid for register file; equals `o_fifoRead`.
- `o_data` out 32: equals `i_fifoData`.
- `o_command` out 8: current command. It is `i_fifoData[31:24]` in IDLE and the latched command otherwise.
- `o_targetVertex` out 2: vertex slot, 0..2.
- `o_loadVertices`, `o_loadUV`, `o_loadRGB`, `o_loadAllRGB` out 1 each: register file load strobes.
- `o_loadSize` out 1, `o_loadSizeParam` out 2, `o_loadRectEdge` out 1, `o_isVertexLoadState` out 1: rectangle size/edge controls.
- `o_bUseTexture` out 1: command bit 26.
- `o_bIgnoreColor` out 1: bit26 & bit24.
- `o_primValid` out 1: primitive loaded, waiting for rasterizer.
- `i_primAck` in 1: rasterizer accepts the primitive.
- `o_unsupported` out 1: one-cycle pulse when an unhandled command word is dropped.
- `o_busy` out 1: state != IDLE.

## Operation
- States: IDLE, COLOR, VERTEX, UV, SIZE, EMIT.
- Latched flags per command:
  - gouraud = bit28.
  - quad = bit27.
  - tex = bit26.
  - rsize = bits[28:27] for rectangles.
- Vertex index `vi` is a 2-bit counter (0..3). Target slot = `vi` for 0..2; `vi` = 3 maps to slot 0.
- IDLE, polygon word: consume it as color of v0 (`o_loadRGB`=1, `o_loadAllRGB` = !gouraud). `vi`=0, go to VERTEX.
- IDLE, rectangle word: consume it with `o_loadRGB`=1 and `o_loadAllRGB`=1. Go to VERTEX.
- IDLE, any other word: consume it, pulse `o_unsupported`, stay in IDLE.
- VERTEX, polygon: `o_loadVertices`=1. Go to UV if tex, else go to next.
- VERTEX, rectangle: `o_loadVertices`=1, target 0.
  - If rsize != 0, also assert `o_loadSize`, `o_loadRectEdge` and `o_isVertexLoadState`, with `o_loadSizeParam` = rsize.
  - Then go to UV if tex, SIZE if rsize == 0, else EMIT.
- UV: `o_loadUV`=1, target = slot(`vi`). Then go to next; for a rectangle, go to SIZE if rsize == 0, else EMIT.
- SIZE: `o_loadSize`=1, `o_loadSizeParam`=0, `o_loadRectEdge`=1, `o_isVertexLoadState`=0. Go to EMIT.
- Next (polygon), evaluated after the vertex's last word:
  - If `vi`==2, or `vi`==3: go to EMIT.
  - Otherwise `vi`++, and go to COLOR if gouraud, else VERTEX.
- COLOR: `o_loadRGB`=1, `o_loadAllRGB`=0, target = slot(`vi`). Go to VERTEX.
- EMIT: `o_primValid`=1 and no FIFO reads. On `i_primAck`:
  - Quad with `vi`==2: set `vi`=3 and go to COLOR/VERTEX. The second triangle uses slots 1, 2, 0.
  - Otherwise go to IDLE.
- In any load state with `i_fifoValid`=0, all strobes are 0 and the state holds; FIFO bubbles are legal anywhere.
- All load strobes are combinational from state and `i_fifoValid`. They are never asserted without `o_fifoRead`.

## Timing
- Throughput: one parameter word per cycle. An untextured flat triangle (4 words) reaches EMIT on the cycle after its 4th read.
- `o_primValid` is registered. It rises the cycle after the final word and holds until the cycle `i_primAck` is sampled high.
- An ack in the same cycle `o_primValid` rises is accepted. The next word may be read the following cycle.
- Reset values: state IDLE, `vi`=0, latched command 0x00, `o_primValid`=0, `o_unsupported`=0, `o_busy`=0. All strobes are 0.
- Reset mid-command: the partial primitive is abandoned and no emit occurs. Register file contents are left untouched.
- `i_primAck` is ignored outside EMIT.

## Configuration
- `GPU_RECT_SEQ_EN` defined: rectangle commands are sequenced as above.
- Not defined: 0x60–0x7F are handled like any other unsupported word (consumed in IDLE, `o_unsupported` pulse). The SIZE state and rectangle paths are removed, and `o_loadSize`, `o_loadRectEdge` and `o_isVertexLoadState` are tied to 0.

## Test plan
- Command 0x20 flat triangle, 4 back-to-back words:
  - Expect reads on cycles 0–3.
  - Cycle 0: `o_loadRGB`=1, `o_loadAllRGB`=1.
  - Cycles 1–3: `o_loadVertices` with targets 0, 1, 2.
  - `o_primValid` on cycle 4.
- Command 0x3C gouraud textured quad, 12 words, ack held low for 3 cycles:
  - First emit after word 9; no read during the wait.
  - Words 10–12 load COLOR/VERTEX/UV at target 0.
  - Second emit, then IDLE.
- Command 0x74 (8×8, textured), 3 words:
  - Vertex word asserts `o_loadRectEdge`=1, `o_isVertexLoadState`=1, `o_loadSizeParam`=2.
  - UV word targets 0, then emit.
- Command 0x60 variable rectangle, words color/vertex/0x00200010:
  - Third word asserts `o_loadSize` with `o_loadSizeParam`=0 and `o_isVertexLoadState`=0, then emit.
  - With `GPU_RECT_SEQ_EN` undefined: a single `o_unsupported` pulse, and the following words are each dropped as unsupported.
- `i_rst` asserted after word 2 of 0x30 → next cycle IDLE, `o_busy`=0. A following 0x20 sequence then behaves as in test 1.
- 0x30 with `i_fifoValid` toggling 1/0 every cycle → identical strobe sequence stretched 2×, with no strobe in a bubble cycle.
